pipe_buffer_ctrl: RTL and testbench
===================================

PIPE_BUFFER_CTRL -- requirements
Module: pipe_buffer_ctrl

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h00000013, the bubble instruction (addi x0,x0,0).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, legal range 1..3, the number of wrong-path fetch slots squashed per taken branch.
REQ-003 SHALL have a single clock and synchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port inst_f  input  32  fetched instruction.
REQ-005 SHALL have port pc_f  input  32  PC of inst_f.
REQ-006 SHALL have port br_taken  input  1  branch/jump resolved taken in stage 1.
REQ-007 SHALL have port mem_wait  input  1  data-memory wait; freezes the pipe.
REQ-008 SHALL have port IRbuffer1_out  output  32  stage-1 (execute) instruction.
REQ-009 SHALL have port IRbuffer2_out  output  32  stage-2 (writeback) instruction.
REQ-010 SHALL have port pc1_out  output  32  PC of IRbuffer1_out.
REQ-011 SHALL have port pc2_out  output  32  PC of IRbuffer2_out.
REQ-012 SHALL have port pc_stall  output  1  hold PC/fetch this cycle.
REQ-013 SHALL have port bubble_cnt  output  16  count of inserted bubbles.

Function
REQ-014 Opcodes: load 0000011, R 0110011, I 0010011, S 0100011, B 1100011, JALR 1100111.
- rs1 is used by R/I/load/S/B/JALR.
- rs2 is used by R/S/B.
REQ-015 load_use SHALL be asserted combinationally when all of the following hold:
- IRbuffer1_out is a load;
- its rd[11:7] != 0;
- inst_f uses rs1 or rs2 equal to that rd.
REQ-016 An internal 2-bit flush_cnt SHALL exist; "flushing" means flush_cnt != 0.
REQ-017 Per-clock priority SHALL be reset > mem_wait > br_taken > flushing > load_use > normal.
REQ-018 mem_wait=1 SHALL hold the following registers unchanged, and br_taken SHALL be ignored that cycle:
- all four buffers;
- flush_cnt;
- bubble_cnt.
REQ-019 br_taken=1 SHALL, on the next clock:
- load buffer1 with NOP_INST;
- set flush_cnt = FLUSH_CYCLES-1;
- move buffer1 into buffer2.
REQ-020 While flushing, each clock SHALL load buffer1 with NOP_INST, decrement flush_cnt and move buffer1 into buffer2.
REQ-021 br_taken during flushing SHALL reload flush_cnt = FLUSH_CYCLES-1; it does not accumulate.
REQ-022 load_use (not flushing, no br_taken, no mem_wait) SHALL, on the next clock, load buffer1 with NOP_INST and move buffer1 (the load) into buffer2.
REQ-023 pc_stall SHALL equal mem_wait OR (load_use AND NOT flushing AND NOT br_taken), and SHALL be 0 while rst_n=0.
REQ-024 The stall SHALL last exactly one cycle per hazard: after the bubble, the load is no longer in buffer1, so the dependent instruction advances with the following clock.
REQ-025 Normal operation SHALL, each clock, perform buffer1<=inst_f, pc1<=pc_f, buffer2<=buffer1 and pc2<=pc1.
REQ-026 pc1 SHALL take pc_f even when a NOP is inserted; pc2 always follows pc1.
REQ-027 bubble_cnt SHALL increment by 1 on every clock that inserts NOP_INST into buffer1 (branch flush or load-use), and SHALL saturate at 16'hFFFF.
REQ-028 All outputs except pc_stall SHALL be registered, with 1-cycle latency from input to buffer1 and 2 cycles to buffer2.
REQ-029 A load in buffer1 with rd=x0 SHALL NOT stall.
REQ-030 An inst_f not using the matching register field (e.g. LUI, JAL) SHALL NOT stall.

Reset
REQ-031 When rst_n=0 at a rising clk, the next state SHALL be:
- IRbuffer1_out = IRbuffer2_out = NOP_INST;
- pc1_out = pc2_out = 0;
- flush_cnt = 0;
- bubble_cnt = 0.
REQ-032 Reset SHALL override mem_wait, br_taken and any in-progress flush or stall.
REQ-033 The first clock after rst_n rises SHALL behave as normal operation.

Verification
REQ-034 Reset check: hold rst_n=0 with mem_wait=1 and br_taken=1 -> after the clock, both buffers = 32'h00000013, pc1/pc2 = 0, bubble_cnt = 0, pc_stall = 0.
REQ-035 Load-use: buffer1 = 0x0000A283 (lw x5), inst_f = 0x00728333 (add x6,x5,x7) -> pc_stall = 1.
- Next clock: buffer1 = NOP, buffer2 = 0x0000A283, bubble_cnt = 1.
- Following clock: buffer1 = 0x00728333, pc_stall = 0.
REQ-036 No false stall: buffer1 = 0x00002003 (lw x0), inst_f reads x0 -> pc_stall = 0 and no bubble; an inst_f of LUI x5 behind lw x5 -> no stall.
REQ-037 Flush: FLUSH_CYCLES = 2, pulse br_taken for one cycle -> exactly 2 consecutive NOPs enter buffer1, bubble_cnt += 2; br_taken re-asserted in the 2nd flush cycle -> flush extends to 3 NOPs total.
REQ-038 Freeze and conflict:
- mem_wait = 1 for 3 cycles during a load-use hazard -> buffers unchanged, pc_stall = 1 throughout, and the bubble is inserted on the first cycle after mem_wait drops.
- br_taken together with load_use -> flush wins and pc_stall = 0.
REQ-039 Saturation: preload bubble_cnt = 16'hFFFE, insert 3 bubbles -> bubble_cnt = 16'hFFFF.

Source files
------------

// File: rtl/pipe_buffer_ctrl.sv
// Two-stage instruction/PC buffer controller for a short in-order pipe.
// Inserts NOP bubbles for load-use hazards and taken-branch flushes, and freezes on mem_wait.
module pipe_buffer_ctrl #(
  parameter logic [31:0] NOP_INST     = 32'h00000013,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_f,
  input  logic [31:0] pc_f,
  input  logic        br_taken,
  input  logic        mem_wait,
  output logic [31:0] IRbuffer1_out,
  output logic [31:0] IRbuffer2_out,
  output logic [31:0] pc1_out,
  output logic [31:0] pc2_out,
  output logic        pc_stall,
  output logic [15:0] bubble_cnt
);

  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpS    = 7'b0100011;
  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpJalr = 7'b1100111;

  localparam logic [1:0] FlushReload = 2'(FLUSH_CYCLES - 1);

  logic [31:0] ir1_q, ir1_d;
  logic [31:0] ir2_q, ir2_d;
  logic [31:0] pc1_q, pc1_d;
  logic [31:0] pc2_q, pc2_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  logic [6:0] op_f;
  logic [4:0] rs1_f, rs2_f, rd_1;
  logic       uses_rs1, uses_rs2;
  logic       load_use;
  logic       flushing;
  logic       insert_nop;

  assign op_f  = inst_f[6:0];
  assign rs1_f = inst_f[19:15];
  assign rs2_f = inst_f[24:20];
  assign rd_1  = ir1_q[11:7];

  assign uses_rs1 = (op_f == OpR) || (op_f == OpI) || (op_f == OpLoad) ||
                    (op_f == OpS) || (op_f == OpB) || (op_f == OpJalr);
  assign uses_rs2 = (op_f == OpR) || (op_f == OpS) || (op_f == OpB);

  assign load_use = (ir1_q[6:0] == OpLoad) && (rd_1 != 5'd0) &&
                    ((uses_rs1 && (rs1_f == rd_1)) || (uses_rs2 && (rs2_f == rd_1)));

  assign flushing = (flush_cnt_q != 2'd0);

  assign pc_stall = rst_n && (mem_wait || (load_use && !flushing && !br_taken));

  always_comb begin
    ir1_d        = ir1_q;
    ir2_d        = ir2_q;
    pc1_d        = pc1_q;
    pc2_d        = pc2_q;
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    insert_nop   = 1'b0;

    // mem_wait freezes everything, including a branch arriving this cycle.
    if (!mem_wait) begin
      ir2_d = ir1_q;
      pc2_d = pc1_q;
      pc1_d = pc_f;
      ir1_d = inst_f;

      if (br_taken) begin
        insert_nop  = 1'b1;
        flush_cnt_d = FlushReload;
      end else if (flushing) begin
        insert_nop  = 1'b1;
        flush_cnt_d = flush_cnt_q - 2'd1;
      end else if (load_use) begin
        insert_nop = 1'b1;
      end

      if (insert_nop) begin
        ir1_d = NOP_INST;
        if (bubble_cnt_q != 16'hFFFF) begin
          bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir1_q        <= NOP_INST;
      ir2_q        <= NOP_INST;
      pc1_q        <= 32'd0;
      pc2_q        <= 32'd0;
      flush_cnt_q  <= 2'd0;
      bubble_cnt_q <= 16'd0;
    end else begin
      ir1_q        <= ir1_d;
      ir2_q        <= ir2_d;
      pc1_q        <= pc1_d;
      pc2_q        <= pc2_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign IRbuffer1_out = ir1_q;
  assign IRbuffer2_out = ir2_q;
  assign pc1_out       = pc1_q;
  assign pc2_out       = pc2_q;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_buffer_ctrl.sv
// Directed bench for pipe_buffer_ctrl with FLUSH_CYCLES = 2: reset, normal flow, load-use,
// false-stall cases, branch flush, mem_wait freeze, branch/load-use conflict and saturation.
module tb_pipe_buffer_ctrl;

  localparam logic [31:0] Nop   = 32'h00000013;
  localparam logic [31:0] AddA  = 32'h003100B3; // add x1,x2,x3
  localparam logic [31:0] AddB  = 32'h00418233; // add x4,x3,x4
  localparam logic [31:0] LwX5  = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] AddX5 = 32'h00728333; // add x6,x5,x7
  localparam logic [31:0] LwX0  = 32'h00002003; // lw x0,0(x0)
  localparam logic [31:0] AddX0 = 32'h00000333; // add x6,x0,x0
  localparam logic [31:0] LuiX5 = 32'h000282B7; // lui x5 with bits[19:15]=5

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_f;
  logic [31:0] pc_f;
  logic        br_taken;
  logic        mem_wait;
  logic [31:0] IRbuffer1_out;
  logic [31:0] IRbuffer2_out;
  logic [31:0] pc1_out;
  logic [31:0] pc2_out;
  logic        pc_stall;
  logic [15:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_buffer_ctrl #(
    .NOP_INST     (Nop),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_f        (inst_f),
    .pc_f          (pc_f),
    .br_taken      (br_taken),
    .mem_wait      (mem_wait),
    .IRbuffer1_out (IRbuffer1_out),
    .IRbuffer2_out (IRbuffer2_out),
    .pc1_out       (pc1_out),
    .pc2_out       (pc2_out),
    .pc_stall      (pc_stall),
    .bubble_cnt    (bubble_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_wait = 1'b1; br_taken = 1'b1; inst_f = LwX5; pc_f = 32'h40;
    step();
    step();
    checks++;
    if (IRbuffer1_out !== Nop) begin
      errors++; $display("FAIL reset_ir1 got=%h exp=%h", IRbuffer1_out, Nop);
    end
    checks++;
    if (IRbuffer2_out !== Nop) begin
      errors++; $display("FAIL reset_ir2 got=%h exp=%h", IRbuffer2_out, Nop);
    end
    checks++;
    if (pc1_out !== 32'd0 || pc2_out !== 32'd0) begin
      errors++; $display("FAIL reset_pc got=%h/%h exp=0/0", pc1_out, pc2_out);
    end
    checks++;
    if (bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt);
    end
    checks++;
    if (pc_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b exp=0", pc_stall);
    end
    rst_n = 1'b1; mem_wait = 1'b0; br_taken = 1'b0;
  endtask

  task automatic test_normal;
    inst_f = AddA; pc_f = 32'h100;
    step();
    checks++;
    if (IRbuffer1_out !== AddA || pc1_out !== 32'h100) begin
      errors++; $display("FAIL normal_s1 got=%h@%h exp=%h@100", IRbuffer1_out, pc1_out, AddA);
    end
    inst_f = AddB; pc_f = 32'h104;
    step();
    checks++;
    if (IRbuffer1_out !== AddB || pc1_out !== 32'h104) begin
      errors++; $display("FAIL normal_s1b got=%h@%h exp=%h@104", IRbuffer1_out, pc1_out, AddB);
    end
    checks++;
    if (IRbuffer2_out !== AddA || pc2_out !== 32'h100) begin
      errors++; $display("FAIL normal_s2 got=%h@%h exp=%h@100", IRbuffer2_out, pc2_out, AddA);
    end
    checks++;
    if (bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL normal_bubble got=%0d exp=0", bubble_cnt);
    end
  endtask

  task automatic test_load_use;
    inst_f = LwX5; pc_f = 32'h200;
    step();
    inst_f = AddX5; pc_f = 32'h204;
    #1;
    checks++;
    if (pc_stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall got=%b exp=1", pc_stall);
    end
    step();
    checks++;
    if (IRbuffer1_out !== Nop || IRbuffer2_out !== LwX5) begin
      errors++; $display("FAIL lu_bubble got=%h/%h exp=%h/%h", IRbuffer1_out, IRbuffer2_out,
                         Nop, LwX5);
    end
    checks++;
    if (bubble_cnt !== 16'd1 || pc1_out !== 32'h204) begin
      errors++; $display("FAIL lu_cnt_pc got=%0d/%h exp=1/204", bubble_cnt, pc1_out);
    end
    checks++;
    if (pc_stall !== 1'b0) begin
      errors++; $display("FAIL lu_unstall got=%b exp=0", pc_stall);
    end
    step();
    checks++;
    if (IRbuffer1_out !== AddX5 || pc_stall !== 1'b0) begin
      errors++; $display("FAIL lu_advance got=%h/%b exp=%h/0", IRbuffer1_out, pc_stall, AddX5);
    end
  endtask

  task automatic test_no_false_stall;
    inst_f = LwX0; pc_f = 32'h300;
    step();
    inst_f = AddX0; pc_f = 32'h304;
    #1;
    checks++;
    if (pc_stall !== 1'b0) begin
      errors++; $display("FAIL x0_stall got=%b exp=0", pc_stall);
    end
    step();
    checks++;
    if (IRbuffer1_out !== AddX0 || bubble_cnt !== 16'd1) begin
      errors++; $display("FAIL x0_nobubble got=%h/%0d exp=%h/1", IRbuffer1_out, bubble_cnt, AddX0);
    end
    inst_f = LwX5; pc_f = 32'h308;
    step();
    inst_f = LuiX5; pc_f = 32'h30C;
    #1;
    checks++;
    if (pc_stall !== 1'b0) begin
      errors++; $display("FAIL lui_stall got=%b exp=0", pc_stall);
    end
    step();
    checks++;
    if (IRbuffer1_out !== LuiX5 || bubble_cnt !== 16'd1) begin
      errors++; $display("FAIL lui_nobubble got=%h/%0d exp=%h/1", IRbuffer1_out, bubble_cnt,
                         LuiX5);
    end
  endtask

  task automatic test_flush;
    inst_f = AddA; pc_f = 32'h400; br_taken = 1'b1;
    step();
    br_taken = 1'b0; inst_f = AddB; pc_f = 32'h404;
    checks++;
    if (IRbuffer1_out !== Nop || IRbuffer2_out !== LuiX5) begin
      errors++; $display("FAIL flush_n1 got=%h/%h exp=%h/%h", IRbuffer1_out, IRbuffer2_out,
                         Nop, LuiX5);
    end
    step();
    checks++;
    if (IRbuffer1_out !== Nop || bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL flush_n2 got=%h/%0d exp=%h/3", IRbuffer1_out, bubble_cnt, Nop);
    end
    step();
    checks++;
    if (IRbuffer1_out !== AddB || bubble_cnt !== 16'd3) begin
      errors++; $display("FAIL flush_end got=%h/%0d exp=%h/3", IRbuffer1_out, bubble_cnt, AddB);
    end
    // Re-assert during the second flush slot: three NOPs total.
    br_taken = 1'b1; inst_f = AddA; pc_f = 32'h500;
    step();
    step();
    br_taken = 1'b0;
    checks++;
    if (IRbuffer1_out !== Nop || bubble_cnt !== 16'd5) begin
      errors++; $display("FAIL reflush_n2 got=%h/%0d exp=%h/5", IRbuffer1_out, bubble_cnt, Nop);
    end
    step();
    checks++;
    if (IRbuffer1_out !== Nop || bubble_cnt !== 16'd6) begin
      errors++; $display("FAIL reflush_n3 got=%h/%0d exp=%h/6", IRbuffer1_out, bubble_cnt, Nop);
    end
    step();
    checks++;
    if (IRbuffer1_out !== AddA || bubble_cnt !== 16'd6) begin
      errors++; $display("FAIL reflush_end got=%h/%0d exp=%h/6", IRbuffer1_out, bubble_cnt, AddA);
    end
  endtask

  task automatic test_freeze_conflict;
    inst_f = LwX5; pc_f = 32'h600;
    step();
    inst_f = AddX5; pc_f = 32'h604; mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pc_stall !== 1'b1 || IRbuffer1_out !== LwX5 || IRbuffer2_out !== AddA ||
          pc1_out !== 32'h600 || bubble_cnt !== 16'd6) begin
        errors++; $display("FAIL freeze_%0d got=%b/%h/%h/%h/%0d", i, pc_stall, IRbuffer1_out,
                           IRbuffer2_out, pc1_out, bubble_cnt);
      end
      step();
    end
    mem_wait = 1'b0;
    #1;
    checks++;
    if (pc_stall !== 1'b1) begin
      errors++; $display("FAIL freeze_release_stall got=%b exp=1", pc_stall);
    end
    step();
    checks++;
    if (IRbuffer1_out !== Nop || IRbuffer2_out !== LwX5 || bubble_cnt !== 16'd7) begin
      errors++; $display("FAIL freeze_bubble got=%h/%h/%0d exp=%h/%h/7", IRbuffer1_out,
                         IRbuffer2_out, bubble_cnt, Nop, LwX5);
    end
    step();
    checks++;
    if (IRbuffer1_out !== AddX5) begin
      errors++; $display("FAIL freeze_advance got=%h exp=%h", IRbuffer1_out, AddX5);
    end
    inst_f = LwX5; pc_f = 32'h700;
    step();
    inst_f = AddX5; pc_f = 32'h704; br_taken = 1'b1;
    #1;
    checks++;
    if (pc_stall !== 1'b0) begin
      errors++; $display("FAIL conflict_stall got=%b exp=0", pc_stall);
    end
    step();
    br_taken = 1'b0;
    step();
    checks++;
    if (IRbuffer1_out !== Nop || bubble_cnt !== 16'd9) begin
      errors++; $display("FAIL conflict_flush got=%h/%0d exp=%h/9", IRbuffer1_out, bubble_cnt, Nop);
    end
    step();
    checks++;
    if (IRbuffer1_out !== AddX5 || bubble_cnt !== 16'd9) begin
      errors++; $display("FAIL conflict_end got=%h/%0d exp=%h/9", IRbuffer1_out, bubble_cnt,
                         AddX5);
    end
  endtask

  task automatic test_saturation;
    inst_f = AddA; pc_f = 32'h800; br_taken = 1'b1;
    for (int i = 0; i < 65525; i++) step();
    checks++;
    if (bubble_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre got=%h exp=fffe", bubble_cnt);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got=%h exp=ffff", bubble_cnt);
    end
    // Reset mid-flush must clear everything.
    rst_n = 1'b0;
    step();
    checks++;
    if (bubble_cnt !== 16'd0 || IRbuffer1_out !== Nop || pc1_out !== 32'd0) begin
      errors++; $display("FAIL sat_reset got=%h/%h/%h exp=0/%h/0", bubble_cnt, IRbuffer1_out,
                         pc1_out, Nop);
    end
    rst_n = 1'b1; br_taken = 1'b0; inst_f = AddB; pc_f = 32'h900;
    step();
    checks++;
    if (IRbuffer1_out !== AddB || bubble_cnt !== 16'd0) begin
      errors++; $display("FAIL post_reset got=%h/%0d exp=%h/0", IRbuffer1_out, bubble_cnt, AddB);
    end
  endtask

  initial begin
    rst_n = 1'b0; inst_f = Nop; pc_f = 32'd0; br_taken = 1'b0; mem_wait = 1'b0;
    test_reset();
    test_normal();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_freeze_conflict();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
